// File: rtl/vector_mem_sequencer.sv
// ---------------------------------------------------------------------------
// vector_mem_sequencer
//
// MEM-stage sequencer for vector loads and stores. A LANES x ELEM_W vector
// access is split into one ELEM_W-wide memory transaction per lane on a simple
// req/ack port. Lane results of a load are assembled into load_vec, which feeds
// the MEM/WB segment. While an access is in flight the pipeline is stalled.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous, active-high reset
//   start_load   vector load request (sampled in IDLE only)
//   start_store  vector store request (sampled in IDLE only)
//   base_addr    element address of lane 0, captured on accept
//   store_vec    store data, lane i = store_vec[i], captured on accept
//   mem_req      memory transaction valid
//   mem_we       1 = write, 0 = read (meaningful while mem_req is high)
//   mem_addr     element address of the current transaction
//   mem_wdata    write data of the current transaction
//   mem_rdata    read data, valid with mem_ack
//   mem_ack      transaction complete (ignored while mem_req is low)
//   load_vec     assembled load vector
//   stall        freeze the pipeline segments
//   busy         state is not IDLE
//   done         one-cycle pulse when an access completes
//   conflict     one-cycle pulse when load and store start together
// ---------------------------------------------------------------------------
module vector_mem_sequencer #(
  parameter int LANES  = 16,
  parameter int ELEM_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_load,
  input  logic                           start_store,
  input  logic [ADDR_W-1:0]              base_addr,
  input  logic [LANES-1:0][ELEM_W-1:0]   store_vec,
  output logic                           mem_req,
  output logic                           mem_we,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [ELEM_W-1:0]              mem_wdata,
  input  logic [ELEM_W-1:0]              mem_rdata,
  input  logic                           mem_ack,
  output logic [LANES-1:0][ELEM_W-1:0]   load_vec,
  output logic                           stall,
  output logic                           busy,
  output logic                           done,
  output logic                           conflict
);

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                         state_q, state_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic                           op_we_q, op_we_d;
  logic [ADDR_W-1:0]              addr_q, addr_d;
  logic [LANES-1:0][ELEM_W-1:0]   wdata_q, wdata_d;
  logic [LANES-1:0][ELEM_W-1:0]   load_vec_q, load_vec_d;

  logic start_any;
  assign start_any = start_load | start_store;

  // State register. Reset clears everything, so an aborted access leaves no
  // partial load data behind and produces no done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      op_we_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      load_vec_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      op_we_q    <= op_we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      load_vec_q <= load_vec_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    op_we_d    = op_we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    load_vec_d = load_vec_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_any) begin
          addr_d  = base_addr;
          wdata_d = store_vec;
          // Load wins when both requests arrive together.
          op_we_d = start_store & ~start_load;
          idx_d   = '0;
          state_d = S_ACCESS;
        end
      end

      S_ACCESS: begin
        if (mem_ack) begin
          if (!op_we_q) begin
            load_vec_d[idx_q] = mem_rdata;
          end
          // idx is left at the last lane on exit; it is reloaded on accept.
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs. stall and conflict depend on the live start inputs; they are
  // masked by rst so that every output reads 0 while reset is held.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    stall     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    conflict  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        stall    = start_any & ~rst;
        conflict = start_load & start_store & ~rst;
      end

      S_ACCESS: begin
        mem_req   = 1'b1;
        mem_we    = op_we_q;
        // Address wraps modulo 2^ADDR_W.
        mem_addr  = addr_q + ADDR_W'(idx_q);
        mem_wdata = wdata_q[idx_q];
        stall     = 1'b1;
        busy      = 1'b1;
      end

      S_DONE: begin
        // stall is released here so the downstream segment samples load_vec.
        busy = 1'b1;
        done = 1'b1;
      end

      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  assign load_vec = load_vec_q;

endmodule

// File: tb/tb_vector_mem_sequencer.sv
module tb_vector_mem_sequencer;

  localparam int LANES  = 16;
  localparam int ELEM_W = 16;
  localparam int ADDR_W = 16;

  logic                          clk;
  logic                          rst;
  logic                          start_load;
  logic                          start_store;
  logic [ADDR_W-1:0]             base_addr;
  logic [LANES-1:0][ELEM_W-1:0]  store_vec;
  logic                          mem_req;
  logic                          mem_we;
  logic [ADDR_W-1:0]             mem_addr;
  logic [ELEM_W-1:0]             mem_wdata;
  logic [ELEM_W-1:0]             mem_rdata;
  logic                          mem_ack;
  logic [LANES-1:0][ELEM_W-1:0]  load_vec;
  logic                          stall;
  logic                          busy;
  logic                          done;
  logic                          conflict;

  vector_mem_sequencer #(
    .LANES (LANES),
    .ELEM_W(ELEM_W),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start_load (start_load),
    .start_store(start_store),
    .base_addr  (base_addr),
    .store_vec  (store_vec),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .load_vec   (load_vec),
    .stall      (stall),
    .busy       (busy),
    .done       (done),
    .conflict   (conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state: the vector a downstream consumer should see.
  logic [LANES-1:0][ELEM_W-1:0] ref_vec;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [LANES-1:0][ELEM_W-1:0] rand_vec();
    logic [LANES-1:0][ELEM_W-1:0] v;
    for (int i = 0; i < LANES; i++) v[i] = ELEM_W'($urandom);
    return v;
  endfunction

  // One complete access, entered and left at a point between clock edges in
  // the IDLE cycle. abort_lane >= 0 pulses reset right after that lane acks.
  task automatic run_access(input bit ld, input bit st, input logic [ADDR_W-1:0] base,
                            input logic [LANES-1:0][ELEM_W-1:0] sv, input int maxgap,
                            input bit xor_data, input int abort_lane);
    bit                expect_we;
    int                gaps;
    logic [ADDR_W-1:0] a;
    logic [ELEM_W-1:0] rd;
    expect_we = st && !ld;

    // Accept cycle
    start_load  = ld;
    start_store = st;
    base_addr   = base;
    store_vec   = sv;
    mem_ack     = 1'($urandom);
    mem_rdata   = ELEM_W'($urandom);
    #1;
    chk("acc_stall", stall, 1'b1);
    chk("acc_conflict", conflict, ld && st);
    chk("acc_req", mem_req, 1'b0);
    chk("acc_done", done, 1'b0);
    chk("acc_busy", busy, 1'b0);
    @(posedge clk);
    @(negedge clk);
    // Inputs change after accept; the captured copies must be used.
    base_addr = ADDR_W'($urandom);
    store_vec = rand_vec();

    for (int i = 0; i < LANES; i++) begin
      a    = base + ADDR_W'(i);
      gaps = $urandom_range(maxgap, 0);
      rd   = '0;
      for (int g = 0; g <= gaps; g++) begin
        start_load  = 1'($urandom);
        start_store = 1'($urandom);
        rd          = xor_data ? (a ^ 16'hA5A5) : ELEM_W'($urandom);
        mem_ack     = (g == gaps);
        mem_rdata   = rd;
        #1;
        chk("lane_req", mem_req, 1'b1);
        chk("lane_we", mem_we, expect_we);
        chk("lane_addr", mem_addr, a);
        chk("lane_wdata", mem_wdata, sv[i]);
        chk("lane_stall", stall, 1'b1);
        chk("lane_busy", busy, 1'b1);
        chk("lane_done", done, 1'b0);
        chk("lane_conflict", conflict, 1'b0);
        @(posedge clk);
        @(negedge clk);
      end
      if (!expect_we) ref_vec[i] = rd;
      if (i == abort_lane) begin
        start_load  = 1'b0;
        start_store = 1'b0;
        mem_ack     = 1'b0;
        rst         = 1'b1;
        #1;
        ref_vec = '0;
        chk("abort_req", mem_req, 1'b0);
        chk("abort_vec", load_vec, ref_vec);
        chk("abort_done", done, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_stall", stall, 1'b0);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("post_abort_done", done, 1'b0);
        chk("post_abort_req", mem_req, 1'b0);
        return;
      end
    end

    // DONE cycle
    start_load  = 1'b0;
    start_store = 1'b0;
    mem_ack     = 1'($urandom);
    #1;
    chk("done_pulse", done, 1'b1);
    chk("done_req", mem_req, 1'b0);
    chk("done_stall", stall, 1'b0);
    chk("done_busy", busy, 1'b1);
    chk("done_vec", load_vec, ref_vec);
    @(posedge clk);
    @(negedge clk);
    // Back in IDLE
    mem_ack = 1'($urandom);
    #1;
    chk("idle_done", done, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_req", mem_req, 1'b0);
    chk("idle_vec", load_vec, ref_vec);
  endtask

  initial begin
    logic [LANES-1:0][ELEM_W-1:0] sv;
    int                           k;

    // Reset with random inputs
    rst         = 1'b1;
    start_load  = 1'($urandom);
    start_store = 1'b1;
    base_addr   = ADDR_W'($urandom);
    store_vec   = rand_vec();
    mem_ack     = 1'($urandom);
    mem_rdata   = ELEM_W'($urandom);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    ref_vec = '0;
    chk("rst_req", mem_req, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, '0);
    chk("rst_wdata", mem_wdata, '0);
    chk("rst_vec", load_vec, ref_vec);
    chk("rst_stall", stall, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_conflict", conflict, 1'b0);
    start_load  = 1'b0;
    start_store = 1'b0;
    rst         = 1'b0;
    @(negedge clk);

    // Load, ack every cycle, data = addr ^ 0xA5A5
    run_access(1'b1, 1'b0, 16'h0100, rand_vec(), 0, 1'b1, -1);
    for (int i = 0; i < LANES; i++)
      chk("load_lane", load_vec[i], (16'h0100 + ELEM_W'(i)) ^ 16'hA5A5);

    // Store with random ack gaps; load_vec must remain as loaded
    for (int i = 0; i < LANES; i++) sv[i] = 16'h1000 + ELEM_W'(i);
    run_access(1'b0, 1'b1, 16'h0040, sv, 3, 1'b0, -1);

    // Simultaneous starts: load wins
    run_access(1'b1, 1'b1, ADDR_W'($urandom), rand_vec(), 2, 1'b0, -1);

    // Address wrap
    run_access(1'b1, 1'b0, 16'hFFF8, rand_vec(), 1, 1'b1, -1);

    // Reset mid-load after lane 5, then a normal load
    run_access(1'b1, 1'b0, ADDR_W'($urandom), rand_vec(), 1, 1'b0, 5);
    run_access(1'b1, 1'b0, ADDR_W'($urandom), rand_vec(), 0, 1'b0, -1);

    // Random back-to-back traffic
    for (int n = 0; n < 20; n++) begin
      k = $urandom_range(2, 0);
      run_access(k != 1, k != 0, ADDR_W'($urandom), rand_vec(), 3, 1'b0, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vector_mem_sequencer.md
# vector_mem_sequencer

Sequences vector loads and stores in the MEM stage of the vector pipeline. A 16-lane x 16-bit vector access is split into one 16-bit memory transaction per lane over a req/ack port. Load results are assembled into the vector that feeds the MEM/WB segment's `data_vec_mem` input. While an access is in flight, the block stalls the pipeline so that neither the MEM/WB segment nor earlier segments advance.

## Interface
- `LANES`, default 16: number of vector elements per access.
- `ELEM_W`, default 16: element width and memory data width, in bits.
- `ADDR_W`, default 16: element (word) address width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start_load`  in  1  vector load request from MEM-stage control; sampled only in IDLE.
- `start_store`  in  1  vector store request from MEM-stage control; sampled only in IDLE.
- `base_addr`  in  ADDR_W  element address of lane 0; captured on accept.
- `store_vec`  in  LANES x ELEM_W  store data, lane i = `store_vec[i]`; captured on accept.
- `mem_req`  out  1  memory transaction valid.
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req` is high.
- `mem_addr`  out  ADDR_W  element address of the current transaction.
- `mem_wdata`  out  ELEM_W  write data of the current transaction.
- `mem_rdata`  in  ELEM_W  read data; valid in the cycle `mem_ack` is high.
- `mem_ack`  in  1  transaction complete; sampled only while `mem_req` is high.
- `load_vec`  out  LANES x ELEM_W  assembled load vector; drives `data_vec_mem`.
- `stall`  out  1  freeze pipeline segments.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse when an access completes.
- `conflict`  out  1  one-cycle pulse when both starts are accepted together.

## Operation
- **States:** IDLE, ACCESS, DONE. Registers: lane index `idx` (log2(LANES) bits), `op_we`, `addr_q`, `wdata_q` (LANES x ELEM_W), `load_vec`.
- **Reset:** state = IDLE, `idx` = 0, `addr_q` = 0, `wdata_q` = 0, `load_vec` = all zero, `op_we` = 0.
- **Outputs on reset:** `mem_req`, `mem_we`, `stall`, `busy`, `done` and `conflict` are 0; `mem_addr` and `mem_wdata` are 0.
- **IDLE, accepting a request:** if `start_load` or `start_store` is high:
  - capture `base_addr` into `addr_q` and `store_vec` into `wdata_q`;
  - set `op_we` = `start_store` AND NOT `start_load` (load has priority);
  - set `idx` = 0 and go to ACCESS.
- **Conflict:** if both starts are high in IDLE, `conflict` pulses in the accept cycle and the store is dropped.
- **ACCESS:**
  - `mem_req` = 1, `mem_we` = `op_we`.
  - `mem_addr` = `addr_q` + `idx`, truncated mod 2^ADDR_W (wraps, no error).
  - `mem_wdata` = `wdata_q[idx]`.
- **ACCESS, on `mem_ack`:**
  - For a load, `load_vec[idx]` <= `mem_rdata`. For a store, `load_vec` is unchanged.
  - If `idx` == LANES-1, go to DONE; otherwise `idx` <= `idx` + 1.
  - With `mem_ack` low, all state holds and `mem_req` stays high with a stable address and data.
- **DONE:** `done` = 1 for one cycle, `mem_req` = 0, then go to IDLE.
- **Start inputs outside IDLE:** ignored and not queued. The MEM stage holds its request under `stall`, so a start still asserted on the cycle after DONE is taken as a new access.
- **`stall`:** asserted combinationally in IDLE whenever either start is high, and for the whole of ACCESS. It is 0 in DONE, so the pipeline advances in the `done` cycle and the downstream segment samples the completed `load_vec`.
- **`load_vec` hold:** keeps its value between loads and is unchanged by stores. During a load it mixes new and old lanes; this is legal because `stall` is high.
- **`busy`:** 1 in ACCESS and DONE.
- **Reset mid-operation:** aborts immediately and asynchronously. `mem_req` drops in the same instant, all state returns to reset values, and no `done` pulse is produced.

## Timing
- Cycle 0: start accepted in IDLE, with `stall` = 1 combinationally.
- Cycle 1: first `mem_req`.
- With `mem_ack` every cycle, lanes complete in cycles 1..LANES, DONE is cycle LANES+1 and IDLE is cycle LANES+2. Minimum latency from accept to `done` is 17 cycles at the default LANES = 16.
- Each cycle that `mem_ack` is low while `mem_req` is high adds one cycle.
- `mem_addr` and `mem_wdata` change only on the clock edge after an acked cycle.
- Back-to-back accesses: a start in the IDLE cycle after DONE is accepted, giving at least 1 idle cycle between accesses.
- `mem_ack` is ignored when `mem_req` is low.

## Test plan
- **Reset:** assert `rst` with random inputs -> every output is 0, and `load_vec` is all zero.
- **Load, ack every cycle:** `base_addr` = 0x0100, memory returns `mem_rdata` = `mem_addr` ^ 0xA5A5 -> `load_vec[i]` = (0x0100+i) ^ 0xA5A5, `done` in cycle 17, `stall` high in cycles 0-16 and low in cycle 17.
- **Store with random ack gaps (0-3 cycles):** `store_vec[i]` = 0x1000+i, base 0x0040 -> 16 writes with `mem_we` = 1, `mem_addr` = 0x0040..0x004F in order, matching `mem_wdata`, `load_vec` unchanged, `done` exactly once.
- **Simultaneous starts:** both starts high in IDLE -> `conflict` pulses once, all 16 transactions have `mem_we` = 0, and a load result is produced.
- **Address wrap:** load with `base_addr` = 0xFFF8 -> `mem_addr` sequence 0xFFF8..0xFFFF, then 0x0000..0x0007, and lanes are filled in order.
- **Reset mid-operation:** `rst` pulsed after lane 5 acks during a load -> `mem_req` drops at once, `load_vec` = 0, no `done`, and a following load completes normally in 17 cycles.
